// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the
// boot loader and the writable instruction RAM.
package imem_loader_pkg;

  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = 5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } ldState_t;

endpackage

// File: rtl/imem_word_asm.sv
// Little-endian byte-to-word assembler shared by
// the data and checksum phases of the loader.
module imem_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] nextWord,
  output logic        wordDone
);

  logic [1:0]  byteCnt;
  logic [31:0] shiftReg;

  // LSB first: each new byte enters at the top and slides down.
  assign nextWord = {byteIn, shiftReg[31:8]};
  assign wordDone = shiftEn & (byteCnt == 2'd3);

  // Byte counter and shift register advance on each accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byteCnt  <= '0;
      shiftReg <= '0;
    end else if (clr) begin
      byteCnt  <= '0;
      shiftReg <= '0;
    end else if (shiftEn) begin
      byteCnt  <= byteCnt + 2'd1;
      shiftReg <= nextWord;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream boot loader: writes the program
// into instruction RAM and releases the CPU on a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_rst_n,
  output logic [AW:0]   words_loaded
);

  localparam logic [AW:0] ONE      = 1;
  localparam logic [8:0]  DEPTH_W9 = 9'(DEPTH);

  ldState_t    state;
  logic [AW:0] nWords;
  logic [31:0] xorAcc;
  logic [31:0] nextWord;
  logic        wordDone;
  logic        accept;
  logic        asmEn;
  logic        startHit;
  logic [AW:0] wordsNext;

  assign accept    = in_valid & in_ready;
  assign asmEn     = accept & ((state == DATA) | (state == CSUM));
  assign startHit  = start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign wordsNext = words_loaded + ONE;

  imem_word_asm uAsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (startHit),
    .shiftEn  (asmEn),
    .byteIn   (in_data),
    .nextWord (nextWord),
    .wordDone (wordDone)
  );

  // Load sequencer: header, data words, checksum, with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_rst_n    <= 1'b0;
      words_loaded <= '0;
      nWords       <= '0;
      xorAcc       <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rst_n    <= 1'b0;
            words_loaded <= '0;
            xorAcc       <= '0;
          end
        end
        HDR: begin
          if (accept) begin
            if ({1'b0, in_data} > DEPTH_W9) begin
              state    <= ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else if (in_data == 8'd0) begin
              state <= CSUM;
            end else begin
              nWords <= (AW+1)'(in_data);
              state  <= DATA;
            end
          end
        end
        DATA: begin
          if (wordDone) begin
            imem_we      <= 1'b1;
            imem_waddr   <= words_loaded[AW-1:0];
            imem_wdata   <= nextWord;
            xorAcc       <= xorAcc ^ nextWord;
            words_loaded <= wordsNext;
            if (wordsNext == nWords) state <= CSUM;
          end
        end
        CSUM: begin
          if (wordDone) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (nextWord == xorAcc) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
